// File: rtl/nanorv32_tcm_lsu_pkg.sv
// Shared nanorv32 LSU encodings: access sizes, response FSM states and the
// alignment rule used to reject requests before they reach the TCM.
package nanorv32_tcm_lsu_pkg;

    localparam logic [1:0] NANORV32_SIZE_B = 2'b00;
    localparam logic [1:0] NANORV32_SIZE_H = 2'b01;
    localparam logic [1:0] NANORV32_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        NANORV32_LSU_IDLE    = 2'b00,
        NANORV32_LSU_RD_RSP  = 2'b01,
        NANORV32_LSU_WR_RSP  = 2'b10,
        NANORV32_LSU_ERR_RSP = 2'b11
    } lsu_state_t;

    // Reserved size or an address not naturally aligned to the access size.
    function automatic logic lsu_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == 2'b11)
            || (size == NANORV32_SIZE_H && addr_lo[0])
            || (size == NANORV32_SIZE_W && addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/nanorv32_lsu_align.sv
// Purely combinational lane logic: store byte-enables and lane replication on
// the issue side, lane extraction and sign/zero extension on the response side.
module nanorv32_lsu_align
    import nanorv32_tcm_lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  lane_mask,
    output logic [31:0] lane_din,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_addr_lo,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_dout,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        lane_mask = 4'b1111;
        lane_din  = st_wdata;
        case (st_size)
            NANORV32_SIZE_B: begin
                lane_mask = 4'b0001 << st_addr_lo;
                lane_din  = {4{st_wdata[7:0]}};
            end
            NANORV32_SIZE_H: begin
                lane_mask = 4'b0011 << st_addr_lo;
                lane_din  = {2{st_wdata[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                lane_din  = st_wdata;
            end
        endcase
    end

    assign ld_shifted = ld_dout >> {ld_addr_lo, 3'b000};
    assign ld_byte    = ld_shifted[7:0];
    assign ld_half    = ld_addr_lo[1] ? ld_dout[31:16] : ld_dout[15:0];

    always_comb begin
        ld_data = ld_dout;
        case (ld_size)
            NANORV32_SIZE_B: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            NANORV32_SIZE_H: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            default:         ld_data = ld_dout;
        endcase
    end

endmodule

// File: rtl/nanorv32_tcm_lsu.sv
// Load/store initiator for the nanorv32 TCM port: one request per cycle, response one
// cycle after acceptance; loads stall in RD_RSP while the TCM withholds ready.
module nanorv32_tcm_lsu
    import nanorv32_tcm_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  tcm_en,
    output logic [ADDR_WIDTH-1:0] tcm_addr,
    output logic [31:0]           tcm_din,
    output logic [3:0]            tcm_bytesel,
    input  logic [31:0]           tcm_dout,
    input  logic                  tcm_ready_nxt
);

    lsu_state_t  state, state_nxt;
    logic [1:0]  cap_addr_lo;
    logic [1:0]  cap_size;
    logic        cap_unsigned;

    logic        bad;
    logic        can_issue;
    logic        accept;
    logic        rd_done;
    logic [3:0]  lane_mask;
    logic [31:0] lane_din;
    logic [31:0] ld_data;
    logic        unused_addr_hi;

    // Region decode happens upstream; high address bits are intentionally dropped.
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

    assign bad       = lsu_is_bad(req_size, req_addr[1:0]);
    assign can_issue = (state != NANORV32_LSU_RD_RSP) | tcm_ready_nxt;
    assign req_ready = can_issue & (bad | ~req_we | tcm_ready_nxt);
    assign accept    = req_valid & req_ready;
    assign rd_done   = (state == NANORV32_LSU_RD_RSP) & tcm_ready_nxt;

    assign tcm_en      = req_valid & can_issue & ~bad;
    assign tcm_addr    = req_valid ? req_addr[ADDR_WIDTH-1:0] : '0;
    assign tcm_din     = req_valid ? lane_din : 32'h0;
    assign tcm_bytesel = (tcm_en & req_we) ? lane_mask : 4'b0000;

    assign rsp_valid = (state == NANORV32_LSU_WR_RSP) | (state == NANORV32_LSU_ERR_RSP) | rd_done;
    assign rsp_err   = (state == NANORV32_LSU_ERR_RSP);
    assign rsp_rdata = rd_done ? ld_data : 32'h0;

    nanorv32_lsu_align u_align (
        .st_size     (req_size),
        .st_addr_lo  (req_addr[1:0]),
        .st_wdata    (req_wdata),
        .lane_mask   (lane_mask),
        .lane_din    (lane_din),
        .ld_size     (cap_size),
        .ld_addr_lo  (cap_addr_lo),
        .ld_unsigned (cap_unsigned),
        .ld_dout     (tcm_dout),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_nxt = NANORV32_LSU_IDLE;
        if (accept) begin
            if (bad)         state_nxt = NANORV32_LSU_ERR_RSP;
            else if (req_we) state_nxt = NANORV32_LSU_WR_RSP;
            else             state_nxt = NANORV32_LSU_RD_RSP;
        end else if (state == NANORV32_LSU_RD_RSP && !tcm_ready_nxt) begin
            state_nxt = NANORV32_LSU_RD_RSP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= NANORV32_LSU_IDLE;
            cap_addr_lo  <= 2'b00;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept && !bad && !req_we) begin
                cap_addr_lo  <= req_addr[1:0];
                cap_size     <= req_size;
                cap_unsigned <= req_unsigned;
            end
        end
    end

endmodule

// File: tb/tb_nanorv32_tcm_lsu.sv
// Directed plus randomized bench for nanorv32_tcm_lsu against a transaction-level
// reference: a word-array TCM and a single pending-response record.
module tb_nanorv32_tcm_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        tcm_en;
    logic [11:0] tcm_addr;
    logic [31:0] tcm_din;
    logic [3:0]  tcm_bytesel;
    logic [31:0] tcm_dout;
    logic        tcm_ready_nxt;

    always #5 clk = ~clk;

    nanorv32_tcm_lsu #(.ADDR_WIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .tcm_en(tcm_en), .tcm_addr(tcm_addr), .tcm_din(tcm_din),
        .tcm_bytesel(tcm_bytesel), .tcm_dout(tcm_dout), .tcm_ready_nxt(tcm_ready_nxt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: TCM contents and the one outstanding response, if any.
    logic [31:0] mem [1024];
    int          pend_kind;      // 0 none, 1 load, 2 store, 3 error
    int          pend_word, pend_off, pend_size;
    bit          pend_uns;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] load_value(input logic [31:0] word, input int off,
                                               input int size, input bit uns);
        longint bits, sh, v;
        bits = 8 << size;
        sh   = (size == 0) ? 8 * off : (size == 1) ? 8 * (off & 2) : 0;
        v    = (longint'(word) >> sh) % (longint'(1) << bits);
        if (!uns && v >= (longint'(1) << (bits - 1)))
            v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    task automatic step(input bit v, input bit we, input bit [1:0] sz, input bit uns,
                        input bit [31:0] a, input bit [31:0] wd, input bit rdy);
        bit          bad, can, exp_ready, exp_en, exp_rv, exp_err;
        logic [31:0] exp_rdata, exp_din, rep, w;
        logic [3:0]  mask;
        int          off;
        off = int'(a[1:0]);
        req_valid = v; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; tcm_ready_nxt = rdy;
        tcm_dout = (pend_kind == 1) ? mem[pend_word] : $urandom();
        @(negedge clk);

        bad  = (sz == 2'd3) || ((a % (32'd1 << sz)) != 0);
        can  = (pend_kind != 1) || rdy;
        exp_ready = can && (bad || !we || rdy);
        exp_en    = v && can && !bad;
        exp_rv    = (pend_kind == 2) || (pend_kind == 3) || (pend_kind == 1 && rdy);
        exp_err   = (pend_kind == 3);
        exp_rdata = (pend_kind == 1 && rdy) ? load_value(mem[pend_word], pend_off, pend_size, pend_uns) : 32'h0;
        rep  = (sz == 2'd0) ? wd[7:0] * 32'h01010101 : (sz == 2'd1) ? wd[15:0] * 32'h00010001 : wd;
        mask = (sz == 2'd0) ? 4'(1 << off) : (sz == 2'd1) ? 4'(3 << off) : 4'hF;
        exp_din = v ? rep : 32'h0;

        check("req_ready",   32'(req_ready),   32'(exp_ready));
        check("tcm_en",      32'(tcm_en),      32'(exp_en));
        check("tcm_addr",    32'(tcm_addr),    v ? 32'(a[11:0]) : 32'h0);
        check("tcm_din",     tcm_din,          exp_din);
        check("tcm_bytesel", 32'(tcm_bytesel), (exp_en && we) ? 32'(mask) : 32'h0);
        check("rsp_valid",   32'(rsp_valid),   32'(exp_rv));
        check("rsp_err",     32'(rsp_err),     32'(exp_err));
        check("rsp_rdata",   rsp_rdata,        exp_rdata);

        if (pend_kind != 1 || rdy) pend_kind = 0;
        if (v && exp_ready) begin
            if (bad) begin
                pend_kind = 3;
            end else if (we) begin
                pend_kind = 2;
                w = mem[a[11:2]];
                for (int i = 0; i < 4; i++)
                    if (mask[i]) w[8*i +: 8] = rep[8*i +: 8];
                mem[a[11:2]] = w;
            end else begin
                pend_kind = 1; pend_word = int'(a[11:2]);
                pend_off = off; pend_size = int'(sz); pend_uns = uns;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, rdy);
    endtask

    initial begin
        bit          rv, rwe, runs;
        bit [1:0]    rsz;
        bit [31:0]   ra;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; tcm_dout = 32'h0; tcm_ready_nxt = 1'b0;
        pend_kind = 0; pend_word = 0; pend_off = 0; pend_size = 0; pend_uns = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom();

        #3;
        check("rst_req_ready",   32'(req_ready),   32'h1);
        check("rst_rsp_valid",   32'(rsp_valid),   32'h0);
        check("rst_rsp_err",     32'(rsp_err),     32'h0);
        check("rst_rsp_rdata",   rsp_rdata,        32'h0);
        check("rst_tcm_en",      32'(tcm_en),      32'h0);
        check("rst_tcm_addr",    32'(tcm_addr),    32'h0);
        check("rst_tcm_din",     tcm_din,          32'h0);
        check("rst_tcm_bytesel", 32'(tcm_bytesel), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // LW with a known word, then byte/half loads, signed and unsigned.
        mem[4] = 32'hDEADBEEF;
        step(1, 0, 2'd2, 0, 32'h010, 32'h0, 1);
        idle(1);
        mem[4] = 32'h80FF1234;
        step(1, 0, 2'd0, 0, 32'h013, 32'h0, 1);
        step(1, 0, 2'd0, 1, 32'h013, 32'h0, 1);
        step(1, 0, 2'd1, 0, 32'h012, 32'h0, 1);
        idle(1);

        step(1, 1, 2'd0, 0, 32'h021, 32'h000000A5, 1);
        idle(1);

        // Misaligned half, reserved size, then a load accepted in the error cycle.
        step(1, 1, 2'd1, 0, 32'h003, 32'h1234, 1);
        step(1, 0, 2'd3, 0, 32'h040, 32'h0, 1);
        step(1, 0, 2'd2, 0, 32'h008, 32'h0, 1);
        idle(1);

        for (int i = 0; i < 4; i++) step(1, 0, 2'd2, 0, 32'(4 * i), 32'h0, 1);
        idle(1);

        // Two-cycle TCM stall with a second load waiting.
        step(1, 0, 2'd2, 0, 32'h100, 32'h0, 1);
        step(1, 0, 2'd2, 0, 32'h104, 32'h0, 0);
        step(1, 0, 2'd2, 0, 32'h104, 32'h0, 0);
        step(1, 0, 2'd2, 0, 32'h104, 32'h0, 1);
        idle(1);

        // Store held while the TCM is not ready.
        step(1, 1, 2'd2, 0, 32'h200, 32'hCAFEF00D, 0);
        step(1, 1, 2'd2, 0, 32'h200, 32'hCAFEF00D, 1);
        step(1, 0, 2'd2, 0, 32'h200, 32'h0, 1);
        idle(1);

        // Reset while a load response is outstanding.
        step(1, 0, 2'd2, 0, 32'h030, 32'h0, 1);
        req_valid = 1'b0; tcm_ready_nxt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("arst_req_ready", 32'(req_ready), 32'h1);
        check("arst_rsp_rdata", rsp_rdata,      32'h0);
        check("arst_tcm_en",    32'(tcm_en),    32'h0);
        @(negedge clk); rst_n = 1'b1; pend_kind = 0;
        @(posedge clk); #1;
        idle(1);
        idle(1);

        for (int i = 0; i < 600; i++) begin
            rv   = ($urandom_range(0, 3) != 0);
            rwe  = ($urandom_range(0, 9) < 4);
            runs = $urandom_range(0, 1) == 1;
            rsz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ra   = $urandom();
            if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rsz) - 32'd1);
            step(rv, rwe, rsz, runs, ra, $urandom(), $urandom_range(0, 3) != 0);
        end
        idle(1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nanorv32_tcm_lsu.md
# nanorv32_tcm_lsu

Load/store initiator for the nanorv32 tightly coupled memory port. It accepts one CPU data request per cycle, whether byte, halfword or word, signed or unsigned, read or write, and drives the TCM request bus (en/addr/din/bytesel). It then collects the TCM response (dout/ready_nxt) and returns an aligned, sign- or zero-extended read result, or a write acknowledge, one cycle after acceptance. It sits between the CPU execute stage and the TCM controller.

## Interface
- ADDR_WIDTH, 12: TCM byte-address width. tcm_addr carries req_addr[ADDR_WIDTH-1:0]; upper bits are ignored, because region decode happens upstream.
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  CPU request present
- req_ready  output  1  request accepted this cycle when high together with req_valid
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- rsp_valid  output  1  response strobe; the CPU always accepts it
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  misaligned or reserved-size request
- tcm_en  output  1  TCM access enable
- tcm_addr  output  ADDR_WIDTH  TCM byte address
- tcm_din  output  32  lane-replicated store data
- tcm_bytesel  output  4  byte write enables; 0000 = read
- tcm_dout  input  32  TCM read data, valid in the cycle after a read issue
- tcm_ready_nxt  input  1  TCM ready: same cycle for writes, next cycle for reads

## Operation
- States: IDLE, RD_RSP, WR_RSP, ERR_RSP.
- can_issue = IDLE, WR_RSP or ERR_RSP, or RD_RSP with tcm_ready_nxt=1. Back-to-back issue is supported.
- bad = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0).
- tcm_en = req_valid & can_issue & !bad. tcm_addr and tcm_din are driven combinationally from req_*. tcm_bytesel = req_we ? lane_mask : 0000.
- lane_mask: byte → 0001<<addr[1:0]; half → 0011<<addr[1:0]; word → 1111.
- tcm_din: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- req_ready = can_issue & (bad | !req_we | tcm_ready_nxt). A store is accepted only when the TCM signals ready in the same cycle; otherwise tcm_en stays asserted and the request holds.
- On acceptance the next state is: bad → ERR_RSP; load → RD_RSP; store → WR_RSP. With no acceptance: RD_RSP waiting (tcm_ready_nxt=0) stays in RD_RSP; every other state goes to IDLE.
- On a load, addr[1:0], size and unsigned are captured into registers.
- rsp_valid = WR_RSP | ERR_RSP | (RD_RSP & tcm_ready_nxt). rsp_err=1 only in ERR_RSP.
- rsp_rdata in RD_RSP: the captured lane of tcm_dout (byte at addr*8, half at addr[1]*16, or word), extended per captured unsigned/size.
- No tcm_en is ever issued for a bad request.

## Timing
- Request is accepted in cycle N. rsp_valid is asserted in cycle N+1 for all types, given a zero-wait TCM. Each extra cycle of tcm_ready_nxt=0 in RD_RSP adds one cycle and holds req_ready at 0.
- Throughput is one request per cycle, including a load accepted in the same cycle as the previous load's response.
- Reset values: state=IDLE, captured fields=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1. With req_valid=0 after reset, all tcm_* outputs are 0.
- An asynchronous reset while in RD_RSP discards the pending response. No rsp_valid follows; the TCM's own en_r clears on the same reset.
- When a response and a new acceptance occur in the same cycle, the response belongs to the old request and the state advances to the new request's RSP state.

## Structure
- Add the size encodings (NANORV32_SIZE_B/H/W) and the four state encodings to the shared nanorv32_parameters include.
- One combinational sub-module, nanorv32_lsu_align, holds lane_mask/tcm_din generation and load extraction/extension. The top level holds the FSM and the capture registers.

## Test plan
- LW at 0x010 with the TCM returning 0xDEADBEEF: tcm_en=1, bytesel=0000 in N; rsp_valid=1, rdata=0xDEADBEEF, err=0 in N+1.
- LB signed at 0x013 with dout=0x80FF_1234 → rdata=0xFFFFFF80. LBU same → 0x00000080. LH at 0x012 → 0xFFFF80FF.
- SB 0xA5 at 0x021 → bytesel=0010, din=0xA5A5A5A5, rsp_valid in N+1, rdata=0.
- SH at 0x003, and size=11 → no tcm_en, rsp_err=1 in N+1. The next valid request is accepted in the error cycle.
- Four back-to-back LWs at 0x0,0x4,0x8,0xC → four consecutive rsp_valid cycles with matching data; then a TCM stall model holds ready_nxt=0 for 2 cycles → req_ready=0, response delayed 2 cycles.
- rst_n pulsed low during RD_RSP → rsp_valid never asserts for that load, state=IDLE, outputs at reset values.
